// File: rtl/cache_flush_ctrl.sv
// Cache flush sequencer: walks every set/way after a flush request and writes back
// each valid dirty line through the bus write-back handshake, clearing its dirty bit.
module cache_flush_ctrl #(
  parameter int unsigned NUMLINES = 128,
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned SETLEN   = $clog2(NUMLINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushCache,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WbAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WbReq,
  output logic               ClearDirty,
  output logic               FlushBusy,
  output logic               FlushDone
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    CHECK     = 3'd2,
    WRITEBACK = 3'd3,
    DONE      = 3'd4
  } stateT;

  stateT              state;
  logic [NUMWAYS-1:0] PendMask;
  logic [NUMWAYS-1:0] hitMask;
  logic [NUMWAYS-1:0] remMask;
  logic               lastSet;

  // Isolate the lowest set bit so ways are written back in ascending order.
  function automatic logic [NUMWAYS-1:0] lowestOne(input logic [NUMWAYS-1:0] m);
    return m & (~m + NUMWAYS'(1));
  endfunction

  assign hitMask    = ValidWay & DirtyWay;
  assign remMask    = PendMask & ~FlushWay;
  assign lastSet    = (FlushAdr == SETLEN'(NUMLINES - 1));
  // WbReq is only ever high in WRITEBACK, so stray acks elsewhere never clear a line.
  assign ClearDirty = WbReq & WbAck;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      FlushAdr  <= '0;
      PendMask  <= '0;
      FlushWay  <= '0;
      WbReq     <= 1'b0;
      FlushBusy <= 1'b0;
      FlushDone <= 1'b0;
    end else begin
      FlushDone <= 1'b0;
      WbReq     <= 1'b0;
      FlushWay  <= '0;
      case (state)
        IDLE: begin
          if (FlushCache) begin
            state     <= READ;
            FlushAdr  <= '0;
            FlushBusy <= 1'b1;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          PendMask <= hitMask;
          if (|hitMask) begin
            state    <= WRITEBACK;
            WbReq    <= 1'b1;
            FlushWay <= lowestOne(hitMask);
          end else if (lastSet) begin
            state     <= DONE;
            FlushDone <= 1'b1;
          end else begin
            state    <= READ;
            FlushAdr <= FlushAdr + SETLEN'(1);
          end
        end
        WRITEBACK: begin
          if (!WbAck) begin
            WbReq    <= 1'b1;
            FlushWay <= FlushWay;
          end else begin
            PendMask <= remMask;
            if (|remMask) begin
              WbReq    <= 1'b1;
              FlushWay <= lowestOne(remMask);
            end else if (lastSet) begin
              state     <= DONE;
              FlushDone <= 1'b1;
            end else begin
              state    <= READ;
              FlushAdr <= FlushAdr + SETLEN'(1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          FlushAdr  <= '0;
          FlushBusy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          FlushAdr  <= '0;
          FlushBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl: behavioural tag arrays, scripted acks,
// per-cycle output trace and hand-computed cycle/way expectations.
module tb_cache_flush_ctrl;

  localparam int unsigned NUMLINES = 128;
  localparam int unsigned NUMWAYS  = 4;
  localparam int unsigned SETLEN   = 7;
  localparam int          MAXCYC   = 700;

  logic               clk = 1'b0;
  logic               reset;
  logic               FlushCache;
  logic [NUMWAYS-1:0] ValidWay;
  logic [NUMWAYS-1:0] DirtyWay;
  logic               WbAck;
  logic [SETLEN-1:0]  FlushAdr;
  logic [NUMWAYS-1:0] FlushWay;
  logic               WbReq;
  logic               ClearDirty;
  logic               FlushBusy;
  logic               FlushDone;

  cache_flush_ctrl #(.NUMLINES(NUMLINES), .NUMWAYS(NUMWAYS)) dut (
    .clk(clk), .reset(reset), .FlushCache(FlushCache),
    .ValidWay(ValidWay), .DirtyWay(DirtyWay), .WbAck(WbAck),
    .FlushAdr(FlushAdr), .FlushWay(FlushWay), .WbReq(WbReq),
    .ClearDirty(ClearDirty), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );

  always #5 clk = ~clk;

  // Synchronous-read tag arrays: data for FlushAdr appears the following cycle.
  logic [NUMWAYS-1:0] validMem [NUMLINES];
  logic [NUMWAYS-1:0] dirtyMem [NUMLINES];
  always @(posedge clk) begin
    ValidWay <= validMem[FlushAdr];
    DirtyWay <= dirtyMem[FlushAdr];
  end

  int checks   = 0;
  int failures = 0;

  logic               trWb  [MAXCYC];
  logic               trClr [MAXCYC];
  logic [NUMWAYS-1:0] trWay [MAXCYC];
  int                 trAdr [MAXCYC];
  int doneCycle, doneCount, busyCycles, wbCycles, clearCount;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearArrays();
    for (int i = 0; i < NUMLINES; i++) begin
      validMem[i] = 4'hF;
      dirtyMem[i] = 4'h0;
    end
  endtask

  // Pulse FlushCache (sampled at cycle 0) and trace cycles 1.. until one past FlushDone.
  // ackDelay >= 0: ack after that many unacked WbReq cycles; < 0: ack high whenever WbReq is low.
  task automatic runFlush(input int ackDelay, input int repulseAt);
    int waitCnt;
    waitCnt    = 0;
    doneCycle  = -1;
    doneCount  = 0;
    busyCycles = 0;
    wbCycles   = 0;
    clearCount = 0;
    FlushCache = 1'b1;
    @(posedge clk); #1;
    FlushCache = 1'b0;
    for (int c = 1; c < MAXCYC; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      FlushCache = (c == repulseAt);
      trWb[c]  = WbReq;
      trWay[c] = FlushWay;
      trAdr[c] = int'(FlushAdr);
      if (FlushBusy) busyCycles++;
      if (WbReq) wbCycles++;
      if (FlushDone) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (ackDelay < 0) WbAck = !WbReq;
      else if (WbReq) begin
        WbAck = (waitCnt >= ackDelay);
        waitCnt = WbAck ? 0 : waitCnt + 1;
      end else WbAck = 1'b0;
      #1;
      trClr[c] = ClearDirty;
      if (ClearDirty) clearCount++;
      if (doneCycle >= 0 && c > doneCycle) break;
    end
    WbAck      = 1'b0;
    FlushCache = 1'b0;
  endtask

  initial begin
    int adrErr, stable, waited;
    reset      = 1'b1;
    FlushCache = 1'b0;
    WbAck      = 1'b0;
    clearArrays();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(FlushBusy), 0);
    check("rst_done", int'(FlushDone), 0);
    check("rst_wbreq", int'(WbReq), 0);
    check("rst_way", int'(FlushWay), 0);
    check("rst_adr", int'(FlushAdr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Stray ack in IDLE must not clear anything.
    WbAck = 1'b1;
    #1;
    check("idle_ack_clear", int'(ClearDirty), 0);
    WbAck = 1'b0;
    @(posedge clk); #1;

    // Clean cache with acks asserted in every non-writeback cycle.
    runFlush(-1, 0);
    check("clean_done_cycle", doneCycle, 257);
    check("clean_busy_cycles", busyCycles, 257);
    check("clean_wb_cycles", wbCycles, 0);
    check("clean_clear", clearCount, 0);
    check("clean_done_count", doneCount, 1);
    adrErr = 0;
    for (int c = 1; c <= 255; c += 2) if (trAdr[c] != (c - 1) / 2) adrErr++;
    if (trAdr[257] != 127) adrErr++;
    check("clean_adr_walk", adrErr, 0);
    check("clean_idle_after", int'(FlushBusy), 0);

    // Set 5 dirty in ways 1 and 3, immediate acks.
    clearArrays();
    dirtyMem[5] = 4'b1010;
    runFlush(0, 0);
    check("s5_done_cycle", doneCycle, 259);
    check("s5_wb12", int'(trWb[12]), 0);
    check("s5_way13", int'(trWay[13]), 2);
    check("s5_way14", int'(trWay[14]), 8);
    check("s5_wb13_14", int'(trWb[13]) + int'(trWb[14]), 2);
    check("s5_clr13_14", int'(trClr[13]) + int'(trClr[14]), 2);
    check("s5_wb15", int'(trWb[15]), 0);
    check("s5_adr15", trAdr[15], 6);
    check("s5_wb_cycles", wbCycles, 2);

    // Set 3 way 0, ack held off for 4 cycles.
    clearArrays();
    dirtyMem[3] = 4'b0001;
    runFlush(4, 0);
    stable = 0;
    for (int c = 9; c <= 13; c++)
      if (trWb[c] && trWay[c] == 4'b0001 && trAdr[c] == 3 && trClr[c] == (c == 13)) stable++;
    check("s3_hold_stable", stable, 5);
    check("s3_wb8", int'(trWb[8]), 0);
    check("s3_wb14", int'(trWb[14]), 0);
    check("s3_adr14", trAdr[14], 4);
    check("s3_clear_count", clearCount, 1);
    check("s3_done_cycle", doneCycle, 262);

    // Invalid-but-dirty ways on set 0 are skipped.
    clearArrays();
    validMem[0] = 4'b0110;
    dirtyMem[0] = 4'b1111;
    runFlush(0, 0);
    check("s0_way3", int'(trWay[3]), 2);
    check("s0_way4", int'(trWay[4]), 4);
    check("s0_wb_cycles", wbCycles, 2);
    check("s0_adr5", trAdr[5], 1);
    check("s0_done_cycle", doneCycle, 259);

    // Reset in WRITEBACK on set 10 with no ack, then restart.
    clearArrays();
    dirtyMem[10] = 4'b0001;
    FlushCache = 1'b1;
    @(posedge clk); #1;
    FlushCache = 1'b0;
    waited = 1;
    while (!WbReq && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("s10_wb_cycle", waited, 23);
    check("s10_adr", int'(FlushAdr), 10);
    reset = 1'b1;
    @(posedge clk); #1;
    check("s10_rst_wbreq", int'(WbReq), 0);
    check("s10_rst_busy", int'(FlushBusy), 0);
    check("s10_rst_adr", int'(FlushAdr), 0);
    check("s10_rst_way", int'(FlushWay), 0);
    check("s10_rst_clear", int'(ClearDirty), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("s10_idle_busy", int'(FlushBusy), 0);
    dirtyMem[10] = 4'b0000;
    runFlush(0, 0);
    check("restart_adr1", trAdr[1], 0);
    check("restart_done_cycle", doneCycle, 257);

    // FlushCache re-pulsed mid-walk is ignored.
    runFlush(0, 50);
    check("repulse_done_count", doneCount, 1);
    check("repulse_done_cycle", doneCycle, 257);
    check("repulse_adr51", trAdr[51], 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
